// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two requesters (port 0 = ALU/execute, port 1 = load/CSR) each feed a private FIFO through
// a valid/ready handshake. A round-robin arbiter pops one entry per cycle into a registered
// write stage driving the register file write port. pending_mask flags every register with a
// queued or staged write so the hazard unit can stall readers.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [ADDRESS_WIDTH-1:0]      req0_addr,
    input  logic [DATA_WIDTH-1:0]         req0_data,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [ADDRESS_WIDTH-1:0]      req1_addr,
    input  logic [DATA_WIDTH-1:0]         req1_data,
    output logic                          rf_we,
    output logic [ADDRESS_WIDTH-1:0]      rf_addr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    output logic [2**ADDRESS_WIDTH-1:0]   pending_mask,
    output logic                          idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [1:0]               push;
    logic [1:0]               pop;
    logic [1:0]               not_empty;
    logic [ADDRESS_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0]    req_data  [2];
    logic [ADDRESS_WIDTH-1:0] fifo_addr [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data [2][FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr    [2];
    logic [PTR_W-1:0]         rd_ptr    [2];
    logic [CNT_W-1:0]         count     [2];
    logic                     last_grant;
    logic                     pop_sel;
    logic [ADDRESS_WIDTH-1:0] pop_addr;
    logic [DATA_WIDTH-1:0]    pop_data;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_addr[0] = req0_addr;
    assign req_addr[1] = req1_addr;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;
    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];

    // Ready depends only on the registered count, so a full FIFO refuses even while popping.
    assign req_ready[0] = (count[0] != CNT_W'(FIFO_DEPTH));
    assign req_ready[1] = (count[1] != CNT_W'(FIFO_DEPTH));
    assign not_empty[0] = (count[0] != '0);
    assign not_empty[1] = (count[1] != '0);
    assign push         = req_valid & req_ready;

    // An entry at slot idx is live when its distance from the read pointer is below count.
    function automatic logic slot_live(input logic [PTR_W-1:0] idx,
                                       input logic [PTR_W-1:0] rd,
                                       input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = idx - rd;
        return ({1'b0, off} < cnt);
    endfunction

    // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                if (push[p] && !pop[p])      count[p] <= count[p] + CNT_W'(1);
                else if (!push[p] && pop[p]) count[p] <= count[p] - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because count alone defines which slots are live.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                fifo_addr[p][wr_ptr[p]] <= req_addr[p];
                fifo_data[p][wr_ptr[p]] <= req_data[p];
            end
        end
    end

    // Round-robin pop: a lone non-empty FIFO wins outright, a contest goes to the other port.
    always_comb begin
        pop = 2'b00;
        if (not_empty == 2'b11) pop = last_grant ? 2'b01 : 2'b10;
        else                    pop = not_empty;
    end

    assign pop_sel  = pop[1];
    assign pop_addr = fifo_addr[pop_sel][rd_ptr[pop_sel]];
    assign pop_data = fifo_data[pop_sel][rd_ptr[pop_sel]];

    // Write stage: x0 entries are consumed but never raise the write enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
            last_grant <= 1'b1;
        end else begin
            rf_we <= 1'b0;
            if (|pop) begin
                rf_we    <= (pop_addr != '0);
                rf_addr  <= pop_addr;
                rf_wdata <= pop_data;
            end
            if (not_empty == 2'b11) last_grant <= pop[1];
        end
    end

    // Pending mask: every live FIFO entry plus the staged write; x0 never counts as a hazard.
    always_comb begin
        pending_mask = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (slot_live(PTR_W'(i), rd_ptr[p], count[p]))
                    pending_mask[fifo_addr[p][i]] = 1'b1;
            end
        end
        if (rf_we) pending_mask[rf_addr] = 1'b1;
        pending_mask[0] = 1'b0;
    end

    assign idle = !not_empty[0] && !not_empty[1] && !rf_we;

endmodule
